// File: rtl/strobe_period_checker.sv
// strobe_period_checker
//   Watches a one-cycle strobe stream that should repeat every PERIOD cycles.
//   It acquires lock after LOCK_COUNT consecutive on-time strobes. Once locked
//   it flywheels through missing or early strobes, counting each one as an
//   error, and drops lock after UNLOCK_COUNT consecutive bad intervals.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   en         checker enable; low forces SEARCH and clears tracking state
//   strobe_in  monitored strobe
//   clr_err    synchronous clear of err_count; wins over a same-cycle error
//   locked     registered lock status (LOCKED or HOLD after the edge)
//   err_pulse  one-cycle pulse, the cycle after each counted error
//   err_count  saturating error count
//   strobe_exp regenerated strobe, combinational from state and cnt
module strobe_period_checker #(
  parameter int PERIOD       = 3,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             strobe_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             strobe_exp
);
  localparam int CW = $clog2(PERIOD + 1);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [CW-1:0] PER     = CW'(PERIOD);
  localparam logic [GW-1:0] GOOD_LST = GW'(LOCK_COUNT - 1);
  localparam logic [BW-1:0] BAD_LIM  = BW'(UNLOCK_COUNT);

  typedef enum logic [1:0] {S_SEARCH, S_ACQ, S_LOCKED, S_HOLD} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [GW-1:0] good, good_n;
  logic [BW-1:0] bad, bad_n, bad_inc;
  logic          due, err, in_lock;

  // cnt == PERIOD marks the cycle a strobe is expected.
  assign due     = (cnt == PER);
  assign cnt_inc = due ? cnt : cnt + CW'(1);
  assign in_lock = (state == S_LOCKED) || (state == S_HOLD);
  // First error out of LOCKED restarts the bad run at 1.
  assign bad_inc = (state == S_LOCKED) ? BW'(1) : bad + BW'(1);

  assign strobe_exp = in_lock && due;

  always_comb begin
    state_n = state;
    cnt_n   = cnt_inc;
    good_n  = good;
    bad_n   = bad;
    err     = 1'b0;
    if (!en) begin
      state_n = S_SEARCH;
      cnt_n   = '0;
      good_n  = '0;
      bad_n   = '0;
    end else begin
      case (state)
        S_SEARCH: begin
          if (strobe_in) begin
            state_n = S_ACQ;
            cnt_n   = CW'(1);
            good_n  = '0;
          end
        end
        S_ACQ: begin
          if (strobe_in && due) begin
            cnt_n  = CW'(1);
            good_n = good + GW'(1);
            if (good == GOOD_LST) begin
              state_n = S_LOCKED;
              bad_n   = '0;
            end
          end else if (strobe_in) begin
            // early strobe re-phases acquisition on itself
            good_n = '0;
            cnt_n  = CW'(1);
          end else if (due) begin
            state_n = S_SEARCH;
          end
        end
        S_LOCKED, S_HOLD: begin
          if (strobe_in && due) begin
            cnt_n   = CW'(1);
            state_n = S_LOCKED;
            bad_n   = '0;
          end else if (strobe_in || due) begin
            // early strobes are ignored (phase kept); misses flywheel
            err   = 1'b1;
            bad_n = bad_inc;
            if (due) cnt_n = CW'(1);
            state_n = (bad_inc == BAD_LIM) ? S_SEARCH : S_HOLD;
          end
        end
        default: state_n = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_SEARCH;
      cnt       <= '0;
      good      <= '0;
      bad       <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      good      <= good_n;
      bad       <= bad_n;
      locked    <= (state_n == S_LOCKED) || (state_n == S_HOLD);
      err_pulse <= err;
      if (clr_err)
        err_count <= '0;
      else if (err && (err_count != {CNT_W{1'b1}}))
        err_count <= err_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_strobe_period_checker.sv
// Scoreboard bench for strobe_period_checker. The driver applies inputs on
// the falling edge, advances a timestamp-based reference model and queues the
// outputs expected after the next rising edge; the monitor pops and compares
// just after each rising edge.
module tb_strobe_period_checker;
  localparam int PERIOD = 3, LOCK_COUNT = 4, UNLOCK_COUNT = 2, CNT_W = 2;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic clk = 1'b0, reset = 1'b1, en = 1'b0, strobe_in = 1'b0, clr_err = 1'b0;
  logic locked, err_pulse, strobe_exp;
  logic [CNT_W-1:0] err_count;

  strobe_period_checker #(.PERIOD(PERIOD), .LOCK_COUNT(LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .strobe_in(strobe_in), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .strobe_exp(strobe_exp));

  always #5 clk = ~clk;

  typedef struct {bit lk; bit ep; int ec; bit se;} exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0;

  // Reference model: modes plus the cycle number of the current phase
  // reference; a strobe is due once PERIOD cycles have elapsed since it.
  typedef enum int {M_SEARCH, M_ACQ, M_LOCK, M_HOLD} mode_t;
  mode_t mode = M_SEARCH;
  int cyc = 0, ref_t = 0, good_run = 0, bad_run = 0, errs = 0;
  bit pulse = 0;

  function automatic bit in_q(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input bit s, input bit e, input bit c, input bit r);
    bit due, err;
    exp_t x;
    due = (cyc - ref_t) >= PERIOD;
    err = 1'b0;
    if (r) begin
      mode = M_SEARCH; errs = 0; pulse = 0; good_run = 0; bad_run = 0;
      ref_t = cyc + 1;
    end else if (!e) begin
      mode = M_SEARCH; pulse = 0; good_run = 0; bad_run = 0;
      ref_t = cyc + 1;
      if (c) errs = 0;
    end else begin
      case (mode)
        M_SEARCH: if (s) begin mode = M_ACQ; ref_t = cyc; good_run = 0; end
        M_ACQ: begin
          if (s && due) begin
            ref_t = cyc; good_run++;
            if (good_run == LOCK_COUNT) begin mode = M_LOCK; bad_run = 0; end
          end else if (s) begin
            good_run = 0; ref_t = cyc;
          end else if (due) mode = M_SEARCH;
        end
        default: begin
          if (s && due) begin
            ref_t = cyc; mode = M_LOCK; bad_run = 0;
          end else if (s || due) begin
            err = 1'b1;
            if (due) ref_t = cyc;
            bad_run = (mode == M_LOCK) ? 1 : bad_run + 1;
            mode = (bad_run == UNLOCK_COUNT) ? M_SEARCH : M_HOLD;
          end
        end
      endcase
      pulse = err;
      if (c) errs = 0;
      else if (err && errs < MAXC) errs++;
    end
    cyc++;
    x.lk = (mode == M_LOCK) || (mode == M_HOLD);
    x.ep = pulse;
    x.ec = errs;
    x.se = x.lk && ((cyc - ref_t) >= PERIOD);
    sb.push_back(x);
  endtask

  task automatic step(input bit s, input bit e, input bit c, input bit r);
    @(negedge clk);
    strobe_in = s; en = e; clr_err = c; reset = r;
    model_step(s, e, c, r);
  endtask

  // Directed run: strobes at listed offsets, optional clr/disable cycle.
  task automatic seq(input int len, input int st[$], input int clr_at, input int dis_at);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    for (int t = 0; t < len; t++)
      step(in_q(st, t), t != dis_at, t == clr_at, 0);
  endtask

  // Monitor
  bit done = 0;
  initial begin
    exp_t x;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        tests++;
        if (locked !== x.lk || err_pulse !== x.ep || int'(err_count) !== x.ec ||
            strobe_exp !== x.se) begin
          fails++;
          $display("FAIL outputs t=%0t: got lk=%b ep=%b ec=%0d se=%b, want lk=%b ep=%b ec=%0d se=%b",
                   $time, locked, err_pulse, err_count, strobe_exp, x.lk, x.ep, x.ec, x.se);
        end
      end
    end
  end

  initial begin
    int ph;
    bit s;
    // lock acquisition
    seq(22, '{0,3,6,9,12,15,18,21}, -1, -1);
    // single missing strobe at 15
    seq(25, '{0,3,6,9,12,18,21,24}, -1, -1);
    // loss of lock, then reacquisition starting at 20
    seq(36, '{0,3,6,9,12,20,23,26,29,32,35}, -1, -1);
    // early strobe while locked
    seq(22, '{0,3,6,9,12,14,15,18,21}, -1, -1);
    // early strobe during acquisition
    seq(22, '{0,3,4,7,10,13,16,19}, -1, -1);
    // saturation, clear with a same-cycle error, then a one-cycle disable
    seq(70, '{0,3,6,9,12,20,23,26,29,32,40,43,46,49,52,60,63,66}, 58, 62);
    // strobe coincident with an unlocking early error is not used for acquisition
    seq(24, '{0,3,6,9,12,13,15,16,17,20,23}, -1, -1);
    // randomized
    ph = 0;
    for (int i = 0; i < 3000; i++) begin
      s = (ph == 0 && $urandom_range(9) != 0) || ($urandom_range(14) == 0);
      ph = ($urandom_range(199) == 0) ? 0 : (ph + 1) % PERIOD;
      step(s, $urandom_range(79) != 0, $urandom_range(39) == 0, $urandom_range(499) == 0);
    end
    step(0, 1, 0, 0);
    @(posedge clk); #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
